// File: rtl/palette_read_arbiter.sv
// Arbitrates a shared combinational palette among requesters and returns
// registered RGB tagged one-hot to the winner, two cycles after accept.
module palette_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [3:0]               rsp_red,
  output logic [3:0]               rsp_green,
  output logic [3:0]               rsp_blue
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [PTR_W-1:0]   rr_ptr;
  logic [7:0]         starve_cnt [1:NUM_REQ-1];
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand_p;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   sel_index;
  logic               found;
  logic               accept;
  logic               s1_valid;
  logic [NUM_REQ-1:0] s1_tag;

  always_comb begin
    int cand;
    grant     = '0;
    gnt_idx   = '0;
    cand_p    = '0;
    sel_index = '0;
    found     = 1'b0;
    cand      = 0;
    // starved requesters beat the renderer, lowest index first
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!found && req_valid[j] && starve_cnt[j] == LIMIT) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    if (!found && req_valid[0]) begin
      found   = 1'b1;
      gnt_idx = '0;
    end
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      cand = int'(rr_ptr) - 1 + k;
      if (cand >= NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
      cand   = cand + 1;
      cand_p = cand[PTR_W-1:0];
      if (!found && req_valid[cand_p]) begin
        found   = 1'b1;
        gnt_idx = cand_p;
      end
    end
    if (found && !Reset) grant[gnt_idx] = 1'b1;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_idx == PTR_W'(j)) sel_index = req_index[j*IDX_W +: IDX_W];
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr <= PTR_W'(1);
    end else if (accept && gnt_idx != '0) begin
      if (gnt_idx == PTR_W'(NUM_REQ - 1)) rr_ptr <= PTR_W'(1);
      else                                 rr_ptr <= gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int j = 1; j < NUM_REQ; j++) starve_cnt[j] <= '0;
    end else begin
      for (int j = 1; j < NUM_REQ; j++) begin
        if (!req_valid[j] || grant[j])  starve_cnt[j] <= '0;
        else if (starve_cnt[j] != LIMIT) starve_cnt[j] <= starve_cnt[j] + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pal_index <= '0;
      s1_tag    <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        pal_index <= sel_index;
        s1_tag    <= grant;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_valid <= '0;
      rsp_red   <= '0;
      rsp_green <= '0;
      rsp_blue  <= '0;
    end else begin
      rsp_valid <= s1_valid ? s1_tag : '0;
      if (s1_valid) begin
        rsp_red   <= pal_red;
        rsp_green <= pal_green;
        rsp_blue  <= pal_blue;
      end
    end
  end

endmodule

// File: tb/tb_palette_read_arbiter.sv
// Directed bench for palette_read_arbiter with a small combinational palette.
module tb_palette_read_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  req_valid;
  logic [15:0] req_index;
  logic [3:0]  req_ready;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_red, rsp_green, rsp_blue;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  function automatic logic [11:0] pal_rgb(input logic [3:0] i);
    return {i ^ 4'h9, i + 4'd3, i - 4'd2};
  endfunction

  assign {pal_red, pal_green, pal_blue} = pal_rgb(pal_index);

  palette_read_arbiter #(.NUM_REQ(4), .IDX_W(4), .STARVE_LIMIT(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid),
    .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue)
  );

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_index = '0;
    Reset = 1'b1;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req_valid = 4'b1111;
    req_index = 16'h1234;
    next_cycle();
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
    total++;
    if (rsp_valid !== 4'b0000 || pal_index !== 4'h0) begin
      bad++; $display("FAIL reset_state rsp=%b idx=%h want 0/0", rsp_valid, pal_index);
    end
    total++;
    if ({rsp_red, rsp_green, rsp_blue} !== 12'h000) begin
      bad++; $display("FAIL reset_rgb got=%h want=000", {rsp_red, rsp_green, rsp_blue});
    end
    req_valid = '0;
    Reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010;
    req_index[7:4] = 4'h5;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL single_ready got=%b want=0010", req_ready);
    end
    next_cycle();
    req_valid = '0;
    total++;
    if (pal_index !== 4'h5 || rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL single_s1 idx=%h rsp=%b want 5/0000", pal_index, rsp_valid);
    end
    next_cycle();
    total++;
    if (rsp_valid !== 4'b0010 || {rsp_red, rsp_green, rsp_blue} !== 12'hC83) begin
      bad++;
      $display("FAIL single_rsp rsp=%b rgb=%h want 0010/C83",
               rsp_valid, {rsp_red, rsp_green, rsp_blue});
    end
    next_cycle();
    total++;
    if (rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL single_pulse rsp=%b want=0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g [0:5];
    logic [3:0] idx;
    g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    req_index = 16'h3210;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b1110 : 4'b0000;
      #1;
      if (c < 6) begin
        total++;
        if (req_ready !== g[c]) begin
          bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, g[c]);
        end
      end
      if (c >= 2 && c < 8) begin
        idx = (g[c-2] == 4'b0010) ? 4'd1 : (g[c-2] == 4'b0100) ? 4'd2 : 4'd3;
        total++;
        if (rsp_valid !== g[c-2] || {rsp_red, rsp_green, rsp_blue} !== pal_rgb(idx)) begin
          bad++;
          $display("FAIL rr_rsp c=%0d rsp=%b rgb=%h want %b/%h", c, rsp_valid,
                   {rsp_red, rsp_green, rsp_blue}, g[c-2], pal_rgb(idx));
        end
      end else if (c < 2 || c == 8) begin
        total++;
        if (rsp_valid !== 4'b0000) begin
          bad++; $display("FAIL rr_idle c=%0d rsp=%b want=0000", c, rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority_starve();
    logic [3:0] exp_g [0:17];
    do_reset();
    req_index = 16'h0700;
    for (int c = 0; c < 18; c++) exp_g[c] = (c == 8 || c == 17) ? 4'b0100 : 4'b0001;
    for (int c = 0; c < 18; c++) begin
      req_valid = 4'b0101;
      #1;
      total++;
      if (req_ready !== exp_g[c]) begin
        bad++; $display("FAIL prio_grant c=%0d got=%b want=%b", c, req_ready, exp_g[c]);
      end
      if (c >= 2) begin
        total++;
        if (rsp_valid !== exp_g[c-2]) begin
          bad++; $display("FAIL prio_rsp c=%0d got=%b want=%b", c, rsp_valid, exp_g[c-2]);
        end
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_simul_starve();
    logic [3:0] want;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_valid = 4'b1011;
      #1;
      want = (c == 8) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0001;
      total++;
      if (req_ready !== want) begin
        bad++; $display("FAIL simul_grant c=%0d got=%b want=%b", c, req_ready, want);
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b0001;
    req_index = 16'h000A;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL mid_ready got=%b want=0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    Reset = 1'b1;
    #1;
    total++;
    if (pal_index !== 4'h0 || rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL mid_async idx=%h rsp=%b want 0/0000", pal_index, rsp_valid);
    end
    next_cycle();
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rsp_valid !== 4'b0000 || {rsp_red, rsp_green, rsp_blue} !== 12'h000) begin
        bad++;
        $display("FAIL mid_drop c=%0d rsp=%b rgb=%h want 0000/000", c, rsp_valid,
                 {rsp_red, rsp_green, rsp_blue});
      end
      next_cycle();
    end
    req_valid = 4'b1110;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL mid_rrptr got=%b want=0010", req_ready);
    end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      req_valid = (c < 16) ? 4'b0001 : 4'b0000;
      req_index = {12'h000, 4'(c)};
      #1;
      if (c < 16) begin
        total++;
        if (req_ready !== 4'b0001) begin
          bad++; $display("FAIL b2b_ready c=%0d got=%b want=0001", c, req_ready);
        end
      end
      if (c >= 1 && c <= 16) begin
        e = 4'(c - 1);
        total++;
        if (pal_index !== e) begin
          bad++; $display("FAIL b2b_idx c=%0d got=%h want=%h", c, pal_index, e);
        end
      end
      if (c >= 2 && c <= 17) begin
        e = 4'(c - 2);
        total++;
        if (rsp_valid !== 4'b0001 || {rsp_red, rsp_green, rsp_blue} !== pal_rgb(e)) begin
          bad++;
          $display("FAIL b2b_rsp c=%0d rsp=%b rgb=%h want 0001/%h", c, rsp_valid,
                   {rsp_red, rsp_green, rsp_blue}, pal_rgb(e));
        end
      end
      if (c == 18) begin
        total++;
        if (rsp_valid !== 4'b0000) begin
          bad++; $display("FAIL b2b_tail rsp=%b want=0000", rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    Reset = 1'b1;
    req_valid = '0;
    req_index = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority_starve();
    test_simul_starve();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
